// File: rtl/video_mem_arbiter.sv
// rtl/video_mem_arbiter.sv - single-port framebuffer arbiter: display scanout has priority over host access
module video_mem_arbiter #(
   parameter int ADDR_W  = 19,
   parameter int DATA_W  = 8,
   parameter int H_VIDEO = 640,
   parameter int V_VIDEO = 480
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pix_ce,
   input  logic [9:0]        x,
   input  logic [9:0]        y,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              host_req,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_wdata,
   output logic              host_gnt,
   output logic              host_rvalid,
   output logic [DATA_W-1:0] host_rdata,
   output logic [DATA_W-1:0] pix_data,
   output logic              pix_valid,
   output logic              disp_miss
);

   typedef enum logic [2:0] {IDLE, D_ADDR, D_CAP, H_WR, H_RD, H_CAP} state_t;

   localparam logic [9:0] H_LIM = 10'(H_VIDEO);
   localparam logic [9:0] V_LIM = 10'(V_VIDEO);

   state_t            state;
   state_t            state_next;
   logic              disp_go;
   logic              host_go;
   logic              disp_pend;
   logic [ADDR_W-1:0] disp_addr;
   logic              in_area;
   logic              pix_active;
   logic [ADDR_W-1:0] pix_addr;
   logic [ADDR_W-1:0] fetch_addr;

   // y*640 + x as two shifts and adds
   assign in_area    = (x < H_LIM) && (y < V_LIM);
   assign pix_active = pix_ce && in_area;
   assign pix_addr   = (ADDR_W'(y) << 9) + (ADDR_W'(y) << 7) + ADDR_W'(x);
   // a strobe arriving in the same IDLE cycle bypasses the pending latch
   assign fetch_addr = pix_active ? pix_addr : disp_addr;

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      disp_go    = 1'b0;
      host_go    = 1'b0;
      case (state)
         IDLE: begin
            if (disp_pend || pix_active) begin
               disp_go    = 1'b1;
               state_next = D_ADDR;
            end else if (host_req) begin
               host_go    = 1'b1;
               state_next = host_we ? H_WR : H_RD;
            end
         end
         D_ADDR:  state_next = D_CAP;
         D_CAP:   state_next = IDLE;
         H_WR:    state_next = IDLE;
         H_RD:    state_next = H_CAP;
         H_CAP:   state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_addr    <= '0;
         mem_we      <= 1'b0;
         mem_wdata   <= '0;
         host_gnt    <= 1'b0;
         host_rvalid <= 1'b0;
         host_rdata  <= '0;
         pix_data    <= '0;
         pix_valid   <= 1'b0;
         disp_miss   <= 1'b0;
         disp_pend   <= 1'b0;
         disp_addr   <= '0;
      end else begin
         host_gnt    <= host_go;
         mem_we      <= host_go && host_we;
         host_rvalid <= 1'b0;
         pix_valid   <= 1'b0;

         if (disp_go)
            mem_addr <= fetch_addr;
         else if (host_go)
            mem_addr <= host_addr;

         if (host_go && host_we)
            mem_wdata <= host_wdata;

         if (pix_active)
            disp_addr <= pix_addr;

         if (disp_go)
            disp_pend <= 1'b0;
         else if (pix_active)
            disp_pend <= 1'b1;

         if (pix_ce && disp_pend)
            disp_miss <= 1'b1;

         // blanking pixels complete immediately without touching the RAM
         if (pix_ce && !in_area) begin
            pix_data  <= '0;
            pix_valid <= 1'b1;
         end

         if (state == D_CAP) begin
            pix_data  <= mem_rdata;
            pix_valid <= 1'b1;
         end

         if (state == H_CAP) begin
            host_rdata  <= mem_rdata;
            host_rvalid <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_video_mem_arbiter.sv
// tb/tb_video_mem_arbiter.sv - self-checking bench for video_mem_arbiter with a RAM model and reference memory
module tb_video_mem_arbiter;

   localparam int ADDR_W = 19;
   localparam int DATA_W = 8;
   localparam int NWORDS = 307200;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              pix_ce = 1'b0;
   logic [9:0]        x = '0;
   logic [9:0]        y = '0;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              host_req = 1'b0;
   logic              host_we = 1'b0;
   logic [ADDR_W-1:0] host_addr = '0;
   logic [DATA_W-1:0] host_wdata = '0;
   logic              host_gnt;
   logic              host_rvalid;
   logic [DATA_W-1:0] host_rdata;
   logic [DATA_W-1:0] pix_data;
   logic              pix_valid;
   logic              disp_miss;

   video_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .H_VIDEO(640), .V_VIDEO(480)) dut (
      .clk(clk), .rst(rst), .pix_ce(pix_ce), .x(x), .y(y),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
      .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
      .pix_data(pix_data), .pix_valid(pix_valid), .disp_miss(disp_miss)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] pat(input int a);
      return 8'(a * 37 + (a >> 9) + 11);
   endfunction

   // synchronous RAM: contents filled on the first edge, optional backdoor write
   logic [7:0]  ram [0:NWORDS-1];
   bit          loaded = 1'b0;
   logic        bd_en = 1'b0;
   int          bd_addr = 0;
   logic [7:0]  bd_data = '0;

   always @(posedge clk) begin
      if (!loaded) begin
         for (int a = 0; a < NWORDS; a++) ram[a] <= pat(a);
         loaded <= 1'b1;
      end else begin
         if (bd_en) ram[bd_addr] <= bd_data;
         else if (mem_we) ram[mem_addr] <= mem_wdata;
         mem_rdata <= ram[mem_addr];
      end
   end

   int we_cycles = 0;
   always @(negedge clk) if (mem_we === 1'b1) we_cycles <= we_cycles + 1;

   // expected memory contents, written only by the stimulus below
   logic [7:0] ref_w [int];
   function automatic logic [7:0] ref_rd(input int a);
      return ref_w.exists(a) ? ref_w[a] : pat(a);
   endfunction
   function automatic int addr_of(input int xx, input int yy);
      return yy * 640 + xx;
   endfunction

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pix(input int xx, input int yy);
      x = 10'(xx);
      y = 10'(yy);
      pix_ce = 1'b1;
   endtask

   task automatic host(input logic we, input int a, input logic [7:0] d);
      host_req   = 1'b1;
      host_we    = we;
      host_addr  = ADDR_W'(a);
      host_wdata = d;
   endtask

   int t_pix, t_gnt, t_rv, n_pix, n_gnt, n_rv;
   logic [7:0] got_pix, got_rd;

   // fixed-length observation window; strobes dropped after one cycle, request after grant
   task automatic watch(input int cycles);
      t_pix = 0; t_gnt = 0; t_rv = 0; n_pix = 0; n_gnt = 0; n_rv = 0;
      got_pix = '0; got_rd = '0;
      for (int i = 1; i <= cycles; i++) begin
         tick();
         pix_ce = 1'b0;
         if (host_gnt === 1'b1) begin
            host_req = 1'b0;
            n_gnt++;
            if (t_gnt == 0) t_gnt = i;
         end
         if (pix_valid === 1'b1) begin
            n_pix++;
            if (t_pix == 0) begin t_pix = i; got_pix = pix_data; end
         end
         if (host_rvalid === 1'b1) begin
            n_rv++;
            if (t_rv == 0) begin t_rv = i; got_rd = host_rdata; end
         end
      end
   endtask

   initial begin
      int we0, a, xx, yy, op, last_w;
      logic [7:0] d;
      last_w = 0;

      repeat (3) tick();
      chk("rst_mem_addr", 32'(mem_addr), 0);
      chk("rst_mem_we", 32'(mem_we), 0);
      chk("rst_mem_wdata", 32'(mem_wdata), 0);
      chk("rst_gnt", 32'(host_gnt), 0);
      chk("rst_rvalid", 32'(host_rvalid), 0);
      chk("rst_rdata", 32'(host_rdata), 0);
      chk("rst_pix_data", 32'(pix_data), 0);
      chk("rst_pix_valid", 32'(pix_valid), 0);
      chk("rst_miss", 32'(disp_miss), 0);
      rst = 1'b0;
      watch(10);
      chk("idle_pix", n_pix, 0);
      chk("idle_gnt", n_gnt, 0);
      chk("idle_rv", n_rv, 0);
      chk("idle_we", we_cycles, 0);

      bd_en = 1'b1; bd_addr = 645; bd_data = 8'h5A; ref_w[645] = 8'h5A;
      tick();
      bd_en = 1'b0;
      pix(5, 1);
      tick();
      pix_ce = 1'b0;
      chk("p645_addr", 32'(mem_addr), 645);
      chk("p645_valid_early", 32'(pix_valid), 0);
      watch(6);
      chk("p645_lat", t_pix, 2);
      chk("p645_data", 32'(got_pix), 32'h5A);
      chk("p645_count", n_pix, 1);

      we0 = we_cycles;
      host(1'b1, 307199, 8'hC3);
      tick();
      chk("hw_gnt", 32'(host_gnt), 1);
      chk("hw_we", 32'(mem_we), 1);
      chk("hw_addr", 32'(mem_addr), 307199);
      chk("hw_wdata", 32'(mem_wdata), 32'hC3);
      host_req = 1'b0;
      ref_w[307199] = 8'hC3;
      watch(3);
      chk("hw_we_cycles", we_cycles - we0, 1);
      chk("hw_single_gnt", n_gnt, 0);
      host(1'b0, 307199, 8'h00);
      watch(5);
      chk("hr_gnt", t_gnt, 1);
      chk("hr_rv_lat", t_rv, 3);
      chk("hr_rdata", 32'(got_rd), 32'hC3);
      chk("hr_we_cycles", we_cycles - we0, 1);

      pix(0, 0);
      host(1'b0, 1000, 8'h00);
      watch(8);
      chk("col_pix_lat", t_pix, 3);
      chk("col_pix_data", 32'(got_pix), 32'(ref_rd(0)));
      chk("col_gnt_lat", t_gnt, 4);
      chk("col_gnt_count", n_gnt, 1);
      chk("col_rv_lat", t_rv, 6);
      chk("col_rdata", 32'(got_rd), 32'(ref_rd(1000)));

      pix(700, 10);
      watch(5);
      chk("blank_lat", t_pix, 1);
      chk("blank_data", 32'(got_pix), 0);
      chk("blank_count", n_pix, 1);
      chk("blank_addr", 32'(mem_addr), 1000);

      host(1'b0, 2000, 8'h00);
      tick();
      chk("miss_gnt", 32'(host_gnt), 1);
      host_req = 1'b0;
      pix(10, 2);
      tick();
      pix(20, 3);
      tick();
      pix_ce = 1'b0;
      chk("miss_flag", 32'(disp_miss), 1);
      chk("miss_rvalid", 32'(host_rvalid), 1);
      chk("miss_rdata", 32'(host_rdata), 32'(ref_rd(2000)));
      watch(8);
      chk("miss_pix_lat", t_pix, 3);
      chk("miss_pix_count", n_pix, 1);
      chk("miss_pix_data", 32'(got_pix), 32'(ref_rd(addr_of(20, 3))));
      chk("miss_addr", 32'(mem_addr), 32'(addr_of(20, 3)));
      chk("miss_sticky", 32'(disp_miss), 1);

      host(1'b0, 3000, 8'h00);
      tick();
      chk("rstmid_gnt", 32'(host_gnt), 1);
      host_req = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      watch(6);
      chk("rstmid_rv", n_rv, 0);
      chk("rstmid_gnt2", n_gnt, 0);
      chk("rstmid_miss", 32'(disp_miss), 0);
      chk("rstmid_addr", 32'(mem_addr), 0);
      chk("rstmid_rdata", 32'(host_rdata), 0);

      for (int it = 0; it < 40; it++) begin
         op = $urandom_range(0, 5);
         a  = $urandom_range(0, NWORDS - 1);
         d  = 8'($urandom);
         xx = $urandom_range(0, 639);
         yy = $urandom_range(0, 479);
         case (op)
            0: begin
               we0 = we_cycles;
               host(1'b1, a, d);
               ref_w[a] = d;
               last_w = a;
               watch(4);
               chk("rnd_w_gnt", t_gnt, 1);
               chk("rnd_w_we", we_cycles - we0, 1);
            end
            1: begin
               if ($urandom_range(0, 1) == 1) a = last_w;
               host(1'b0, a, 8'h00);
               watch(5);
               chk("rnd_r_gnt", t_gnt, 1);
               chk("rnd_r_lat", t_rv, 3);
               chk("rnd_r_data", 32'(got_rd), 32'(ref_rd(a)));
            end
            2: begin
               pix(xx, yy);
               watch(6);
               chk("rnd_p_lat", t_pix, 3);
               chk("rnd_p_data", 32'(got_pix), 32'(ref_rd(addr_of(xx, yy))));
            end
            3: begin
               if ($urandom_range(0, 1) == 1) xx = $urandom_range(640, 1023);
               else yy = $urandom_range(480, 1023);
               pix(xx, yy);
               watch(4);
               chk("rnd_b_lat", t_pix, 1);
               chk("rnd_b_data", 32'(got_pix), 0);
            end
            4: begin
               host(1'b0, a, 8'h00);
               tick();
               chk("rnd_wc_gnt", 32'(host_gnt), 1);
               host_req = 1'b0;
               pix(xx, yy);
               watch(8);
               chk("rnd_wc_rv", t_rv, 2);
               chk("rnd_wc_rdata", 32'(got_rd), 32'(ref_rd(a)));
               chk("rnd_wc_plat", t_pix, 5);
               chk("rnd_wc_pdata", 32'(got_pix), 32'(ref_rd(addr_of(xx, yy))));
            end
            default: begin
               we0 = we_cycles;
               pix(xx, yy);
               host(1'b1, a, d);
               watch(8);
               chk("rnd_pw_plat", t_pix, 3);
               chk("rnd_pw_pdata", 32'(got_pix), 32'(ref_rd(addr_of(xx, yy))));
               chk("rnd_pw_gnt", t_gnt, 4);
               chk("rnd_pw_we", we_cycles - we0, 1);
               ref_w[a] = d;
               last_w = a;
            end
         endcase
      end
      chk("rnd_no_miss", 32'(disp_miss), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/video_mem_arbiter.md
Name: video_mem_arbiter

Overview:
Shares one single-port synchronous framebuffer RAM between display scanout and a host (CPU/drawing engine) port. On each pixel strobe from the sync generator it fetches the pixel at (x,y) and presents it to the video output. Host reads and writes use the remaining memory cycles. The block sits between the 640x480 sync/timing generator, the framebuffer RAM and the host bus. Display fetches have strict priority.

Parameters:
ADDR_W, 19, framebuffer address width (640*480 = 307200 words)
DATA_W, 8, pixel/word width
H_VIDEO, 640, active pixels per line
V_VIDEO, 480, active lines per frame

Ports:
clk  in  1  system clock
rst  in  1  reset
pix_ce  in  1  one-clk strobe, one per pixel period; minimum spacing 8 clk
x  in  10  column of the pixel to fetch, valid with pix_ce
y  in  10  row of the pixel to fetch, valid with pix_ce
mem_addr  out  ADDR_W  RAM address (registered)
mem_we  out  1  RAM write enable (registered)
mem_wdata  out  DATA_W  RAM write data (registered)
mem_rdata  in  DATA_W  RAM read data, valid 1 clk after the RAM samples mem_addr
host_req  in  1  host request; held with addr/we/wdata until host_gnt
host_we  in  1  1 = write, 0 = read
host_addr  in  ADDR_W  host address
host_wdata  in  DATA_W  host write data
host_gnt  out  1  one-clk pulse: request accepted
host_rvalid  out  1  one-clk pulse: host_rdata valid
host_rdata  out  DATA_W  host read data, held until next rvalid
pix_data  out  DATA_W  fetched pixel, held until next pix_valid
pix_valid  out  1  one-clk pulse: pix_data updated
disp_miss  out  1  sticky: display request overrun; cleared only by rst

Behaviour:
- Reset: clk and rst as stated: reset rst, synchronous, active-high; clock clk. On rst, all outputs go to 0, FSM goes to IDLE, and the pending display flag clears. Any in-flight host transaction is abandoned with no gnt or rvalid. Reset mid-operation gives the same result.
- pix_ce with x<H_VIDEO and y<V_VIDEO: latch disp_addr = (y<<9)+(y<<7)+x (ADDR_W bits) and set disp_pend.
- pix_ce outside the active area: no memory cycle. At the next edge, pix_data<=0 and pix_valid pulses.
- pix_ce while disp_pend is still set: set disp_miss. The new address overwrites the old one, and only one fetch is issued.
- FSM states: IDLE, D_ADDR, D_CAP, H_WR, H_RD, H_CAP.
- IDLE: if disp_pend or an active pix_ce this cycle, go to D_ADDR. Load mem_addr<=disp_addr and mem_we<=0, then clear disp_pend.
  - Else if host_req: pulse host_gnt, load mem_addr<=host_addr, then
    - host_we=1: set mem_we<=1 and mem_wdata<=host_wdata, go to H_WR;
    - host_we=0: set mem_we<=0, go to H_RD.
- D_ADDR -> D_CAP (RAM samples the address).
- D_CAP: pix_data<=mem_rdata, pix_valid pulse, go to IDLE.
- H_WR: mem_we<=0, go to IDLE.
- H_RD -> H_CAP.
- H_CAP: host_rdata<=mem_rdata, host_rvalid pulse, go to IDLE.
- Display latency, pix_ce sample edge to pix_valid-high edge: 3 clk if the FSM is IDLE, worst case 5 clk if a host read is in flight. A host op never preempts a pending display fetch.
- Host throughput: write occupies 2 clk, read 3 clk. The host may be starved only while display requests are pending.
- pix_ce and host_req in the same IDLE cycle: display wins. host_gnt stays low and the host retries on a later IDLE cycle.
- mem_we is high for exactly one clk per granted write and never during a display cycle.
- Address arithmetic is unsigned. x and y are at most 10 bits, so the maximum address is 307199 and there is no overflow.

Test Plan:
- Reset then idle, no requests -> every output 0, mem_we never asserts.
- Preload RAM[645]=0x5A; pix_ce with x=5, y=1 -> mem_addr=645 one clk later, pix_valid with pix_data=0x5A 3 clk after pix_ce.
- Host write addr 307199 data 0xC3, then host read of the same address -> host_gnt pulses twice, mem_we high 1 clk, host_rvalid with host_rdata=0xC3.
- pix_ce (x=0, y=0) and host_req read in the same cycle -> display fetch first, host_gnt 3 clk later, host read completes afterward.
- pix_ce with x=700, y=10 -> no mem access, pix_valid next clk with pix_data=0.
- Two pix_ce 1 clk apart while a host read is in flight -> disp_miss=1 and stays set, a single fetch of the second address is issued; rst mid-host-read -> no host_rvalid, disp_miss=0.
